// File: rtl/pio_key_in_pkg.sv
// Shared register offsets and edge-select codes for the key/switch input PIO.
// Also holds the helper that decides whether a debounced transition gets latched.
package pio_key_in_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE    = 2'd3;

    localparam int EDGE_FALL = 0;
    localparam int EDGE_RISE = 1;
    localparam int EDGE_ANY  = 2;

    function automatic logic edge_hit(input int edge_type, input logic rise, input logic fall);
        logic hit;
        hit = 1'b0;
        case (edge_type)
            EDGE_FALL: hit = fall;
            EDGE_RISE: hit = rise;
            default:   hit = rise | fall;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/pio_key_in_debounce.sv
// One input bit: 2-flop synchroniser, stability counter and debounced level.
// rise/fall pulse combinationally in the cycle whose edge updates stable.
module pio_debounce #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          differ;
    logic          accept;

    assign differ = (s2 != stable);
    assign accept = differ && (cnt == CNT_LAST);
    assign rise   = accept &  s2;
    assign fall   = accept & ~s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= IDLE_LEVEL;
            s2     <= IDLE_LEVEL;
            stable <= IDLE_LEVEL;
            cnt    <= '0;
        end else begin
            s1 <= pin;
            s2 <= s1;
            // Any cycle where the synchronised pin agrees with stable restarts the window.
            if (!differ) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pio_key_in.sv
// Avalon-MM input PIO: debounced key pins, sticky edge capture, maskable level irq.
// Zero-wait-state: readdata is a pure mux of address; writes take effect next cycle.
module pio_key_in
    import pio_key_in_pkg::*;
#(
    parameter int   WIDTH           = 4,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter int   EDGE_TYPE       = 0,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] mux_out;
    logic [31:0]      rd_word;
    logic             wr_mask;
    logic             wr_edge;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_LEVEL      (IDLE_LEVEL)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .pin    (in_port[i]),
            .stable (stable[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    if (WIDTH < 32) begin : g_unused
        logic unused_wd;
        assign unused_wd = ^writedata[31:WIDTH];
    end

    assign wr_mask  = chipselect && !write_n && (address == PIO_ADDR_IRQMASK);
    assign wr_edge  = chipselect && !write_n && (address == PIO_ADDR_EDGE);
    assign edge_clr = wr_edge ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        edge_set = '0;
        for (int i = 0; i < WIDTH; i++) begin
            edge_set[i] = edge_hit(EDGE_TYPE, rise[i], fall[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            if (wr_mask) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            // Set is ORed after the clear so a simultaneous edge survives the W1C.
            edge_capture <= (edge_capture & ~edge_clr) | edge_set;
        end
    end

    always_comb begin
        mux_out = '0;
        case (address)
            PIO_ADDR_DATA:    mux_out = stable;
            PIO_ADDR_DIR:     mux_out = '0;
            PIO_ADDR_IRQMASK: mux_out = irq_mask;
            PIO_ADDR_EDGE:    mux_out = edge_capture;
            default:          mux_out = '0;
        endcase
        rd_word              = '0;
        rd_word[WIDTH-1:0]   = mux_out;
    end

    assign readdata = rd_word;
    assign irq      = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_pio_key_in.sv
// Bench for pio_key_in: falling-edge and any-edge instances share stimulus and are
// checked against a sample-window reference model plus directed constant expectations.
module tb_pio_key_in;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [3:0]  in_port = 4'hF;
    logic [31:0] rd_f;
    logic [31:0] rd_a;
    logic        irq_f;
    logic        irq_a;

    int checks = 0;
    int errors = 0;

    // Reference state: pin samples per edge, debounced level, captures, mask.
    logic [3:0] hist[$];
    logic [3:0] st_m;
    logic [3:0] capf_m;
    logic [3:0] capa_m;
    logic [3:0] mask_m;

    always #5 clk = ~clk;

    pio_key_in #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0), .IDLE_LEVEL(1'b1)) dut_f (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_f), .irq(irq_f)
    );

    pio_key_in #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2), .IDLE_LEVEL(1'b1)) dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_a), .irq(irq_a)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // A level is accepted once the last D synchronised samples all disagree with it;
    // the synchroniser makes the sample seen at edge k the pin value from edge k-2.
    task automatic model_step();
        logic [3:0] new_st, rise, fall, clr;
        if (reset) begin
            hist.delete();
            for (int i = 0; i < D + 2; i++) hist.push_back(4'hF);
            st_m = 4'hF; capf_m = '0; capa_m = '0; mask_m = '0;
        end else begin
            hist.push_back(in_port);
            if (hist.size() > D + 2) void'(hist.pop_front());
            new_st = st_m;
            for (int b = 0; b < 4; b++) begin
                bit all_diff;
                all_diff = 1'b1;
                for (int j = 0; j < D; j++)
                    if (hist[hist.size() - 3 - j][b] == st_m[b]) all_diff = 1'b0;
                if (all_diff) new_st[b] = hist[hist.size() - 3][b];
            end
            rise = new_st & ~st_m;
            fall = ~new_st & st_m;
            clr = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
            capf_m = (capf_m & ~clr) | fall;
            capa_m = (capa_m & ~clr) | rise | fall;
            if (chipselect && !write_n && address == 2'd2) mask_m = writedata[3:0];
            st_m = new_st;
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        tick();
        write_n = 1'b1; chipselect = 1'b0; writedata = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] vf, output logic [31:0] va);
        address = a;
        #1;
        vf = rd_f;
        va = rd_a;
    endtask

    task automatic check_model(input string tag);
        logic [31:0] vf, va, ef, ea;
        check({tag, ".irq_f"}, {31'd0, irq_f}, {31'd0, |(capf_m & mask_m)});
        check({tag, ".irq_a"}, {31'd0, irq_a}, {31'd0, |(capa_m & mask_m)});
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), vf, va);
            case (a)
                0: begin ef = {28'd0, st_m};   ea = ef; end
                1: begin ef = 32'd0;           ea = ef; end
                2: begin ef = {28'd0, mask_m}; ea = ef; end
                default: begin ef = {28'd0, capf_m}; ea = {28'd0, capa_m}; end
            endcase
            check($sformatf("%s.f_addr%0d", tag, a), vf, ef);
            check($sformatf("%s.a_addr%0d", tag, a), va, ea);
        end
    endtask

    initial begin
        logic [31:0] vf, va;
        int hold;

        // Reset with keys idle high
        reset = 1'b1; in_port = 4'hF;
        tick(3);
        reset = 1'b0;
        rd(2'd0, vf, va); check("rst_addr0", vf, 32'hF);
        rd(2'd2, vf, va); check("rst_addr2", vf, 32'h0);
        rd(2'd3, vf, va); check("rst_addr3", vf, 32'h0);
        check("rst_irq", {31'd0, irq_f}, 32'd0);
        check_model("rst");

        // Short glitch is rejected, a held press lands on the 6th edge
        in_port = 4'hE; tick(3);
        in_port = 4'hF; tick(6);
        rd(2'd0, vf, va); check("glitch_addr0", vf, 32'hF);
        rd(2'd3, vf, va); check("glitch_addr3", vf, 32'h0);
        in_port = 4'hE; tick(5);
        rd(2'd0, vf, va); check("press_early_addr0", vf, 32'hF);
        tick(1);
        rd(2'd0, vf, va); check("press_addr0", vf, 32'hE);
        rd(2'd3, vf, va); check("press_addr3", vf, 32'h1);
        check_model("press");

        // Release: falling-only instance ignores it, any-edge instance latches it
        wr(2'd3, 32'hF);
        wr(2'd2, 32'h1);
        check("irq_after_clear", {31'd0, irq_f}, 32'd0);
        in_port = 4'hF; tick(6);
        rd(2'd3, vf, va);
        check("release_f_addr3", vf, 32'h0);
        check("release_a_addr3", va, 32'h1);

        // Masked interrupt follows the capture edge, W1C drops it next cycle
        in_port = 4'hE; tick(5);
        check("irq_before_capture", {31'd0, irq_f}, 32'd0);
        tick(1);
        check("irq_on_capture", {31'd0, irq_f}, 32'd1);
        wr(2'd3, 32'h1);
        check("irq_after_w1c", {31'd0, irq_f}, 32'd0);
        wr(2'd2, 32'h0);
        in_port = 4'hF; tick(6);
        in_port = 4'hE; tick(6);
        rd(2'd3, vf, va); check("masked_addr3", vf, 32'h1);
        check("masked_irq", {31'd0, irq_f}, 32'd0);
        check_model("mask");

        // Clear-all write on the same edge that bit2 is captured
        in_port = 4'hA; tick(5);
        wr(2'd3, 32'hF);
        rd(2'd3, vf, va);
        check("collide_f_addr3", vf, 32'h4);
        check("collide_a_addr3", va, 32'h4);
        check_model("collide");

        // Reset in the middle of a bit1 debounce window
        wr(2'd3, 32'hF);
        in_port = 4'hF; tick(6);
        in_port = 4'hD; tick(4);
        reset = 1'b1; tick(1); reset = 1'b0;
        rd(2'd0, vf, va); check("midrst_addr0", vf, 32'hF);
        rd(2'd3, vf, va); check("midrst_addr3", vf, 32'h0);
        tick(5);
        rd(2'd0, vf, va); check("midrst_early_addr0", vf, 32'hF);
        tick(1);
        rd(2'd0, vf, va); check("midrst_press_addr0", vf, 32'hD);
        rd(2'd3, vf, va); check("midrst_press_addr3", vf, 32'h2);
        check_model("midrst");

        // Random pins with random hold times, mask/W1C writes and rare resets
        hold = 0;
        for (int it = 0; it < 400; it++) begin
            if (hold == 0) begin
                in_port = in_port ^ 4'($urandom_range(0, 15));
                hold = $urandom_range(1, 8);
            end
            hold--;
            reset = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 5))
                0: begin address = 2'd2; chipselect = 1'b1; write_n = 1'b0; end
                1: begin address = 2'd3; chipselect = 1'b1; write_n = 1'b0; end
                2: begin address = 2'($urandom_range(0, 1)); chipselect = 1'b1; write_n = 1'b0; end
                default: begin chipselect = 1'b0; write_n = 1'b1; end
            endcase
            writedata = $urandom;
            tick(1);
            reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
            check_model($sformatf("rand%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
